// File: rtl/mcu_bus_pkg.sv
// Shared MCU system-bus definitions: bus widths, region pages and DMA FSM encoding.
package mcu_bus_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned DMA_LEN_W  = 8;
    localparam int unsigned DMA_STRIDE = 1;

    // Address page (bits [15:8]) decoded by the top-level read mux
    localparam logic [7:0] PAGE_ROM  = 8'h00;
    localparam logic [7:0] PAGE_SRAM = 8'h01;
    localparam logic [7:0] PAGE_GPIO = 8'h02;

    typedef enum logic [2:0] {
        DMA_IDLE    = 3'd0,
        DMA_REQ     = 3'd1,
        DMA_RD      = 3'd2,
        DMA_RD_WAIT = 3'd3,
        DMA_WR      = 3'd4,
        DMA_FIN     = 3'd5
    } dma_state_e;

    // Region page of a bus address
    function automatic logic [7:0] addr_page(input logic [BUS_ADDR_W-1:0] addr);
        return addr[15:8];
    endfunction

endpackage

// File: rtl/bus_dma_addr_gen.sv
// Source/destination address and remaining-word counters for the DMA master.
// The *_nxt_c outputs expose the value the pointers take at the coming edge.
module bus_dma_addr_gen
    import mcu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned LEN_W  = DMA_LEN_W,
    parameter int unsigned STRIDE = DMA_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] src_in,
    input  logic [ADDR_W-1:0] dst_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic [ADDR_W-1:0] src_nxt_c,
    output logic [ADDR_W-1:0] dst_nxt_c,
    output logic              last
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRIDE);

    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic [LEN_W-1:0]  remaining;

    // Next pointer values; addition wraps modulo 2^ADDR_W
    always_comb begin
        src_nxt_c = src_cur;
        dst_nxt_c = dst_cur;
        if (load) begin
            src_nxt_c = src_in;
            dst_nxt_c = dst_in;
        end else if (step) begin
            src_nxt_c = src_cur + ADDR_STEP;
            dst_nxt_c = dst_cur + ADDR_STEP;
        end
    end

    // Pointer, count and last-word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_cur   <= '0;
            dst_cur   <= '0;
            remaining <= '0;
            last      <= 1'b0;
        end else begin
            src_cur <= src_nxt_c;
            dst_cur <= dst_nxt_c;
            if (load) begin
                remaining <= len_in;
                last      <= (len_in == LEN_W'(1));
            end else if (step) begin
                remaining <= remaining - LEN_W'(1);
                last      <= (remaining == LEN_W'(2));
            end
        end
    end

endmodule

// File: rtl/bus_dma_master.sv
// Block-copy DMA initiator on the MCU system bus (req/gnt arbitrated).
// Optional fill mode is built in when BUS_DMA_FILL_EN is defined.
module bus_dma_master
    import mcu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = BUS_ADDR_W,
    parameter int unsigned DATA_W = BUS_DATA_W,
    parameter int unsigned LEN_W  = DMA_LEN_W,
    parameter int unsigned STRIDE = DMA_STRIDE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_we,
    input  logic [DATA_W-1:0] m_rdata
`ifdef BUS_DMA_FILL_EN
    ,
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_value
`endif
);

    dma_state_e        state_q, state_d;
    logic              load, step, capture;
    logic              last;
    logic [ADDR_W-1:0] src_nxt_c, dst_nxt_c;
    logic              fill_q;
    logic [DATA_W-1:0] fill_val_q;

    logic              busy_d, done_d, req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              we_q;

    bus_dma_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .src_in    (src_addr),
        .dst_in    (dst_addr),
        .len_in    (len),
        .src_nxt_c (src_nxt_c),
        .dst_nxt_c (dst_nxt_c),
        .last      (last)
    );

`ifdef BUS_DMA_FILL_EN
    // Fill-mode configuration captured with the transfer parameters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 1'b0;
            fill_val_q <= '0;
        end else if (load) begin
            fill_q     <= fill_mode;
            fill_val_q <= fill_value;
        end
    end
`else
    assign fill_q     = 1'b0;
    assign fill_val_q = '0;
`endif

    // Next state, counter control and next registered bus outputs
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        capture = 1'b0;

        case (state_q)
            DMA_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        load    = 1'b1;
                        state_d = DMA_REQ;
                    end else begin
                        state_d = DMA_FIN;
                    end
                end
            end
            DMA_REQ: begin
                if (bus_gnt) state_d = fill_q ? DMA_WR : DMA_RD;
            end
            DMA_RD: begin
                state_d = bus_gnt ? DMA_RD_WAIT : DMA_REQ;
            end
            DMA_RD_WAIT: begin
                if (bus_gnt) begin
                    capture = 1'b1;
                    state_d = DMA_WR;
                end else begin
                    state_d = DMA_REQ;
                end
            end
            DMA_WR: begin
                if (bus_gnt) begin
                    step = 1'b1;
                    if (last)        state_d = DMA_FIN;
                    else if (fill_q) state_d = DMA_WR;
                    else             state_d = DMA_RD;
                end else begin
                    state_d = DMA_REQ;
                end
            end
            DMA_FIN: begin
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase

        busy_d = (state_d != DMA_IDLE);
        done_d = (state_q == DMA_FIN);
        req_d  = state_d inside {DMA_REQ, DMA_RD, DMA_RD_WAIT, DMA_WR};
        we_d   = (state_d == DMA_WR);

        addr_d = '0;
        if (state_d == DMA_RD || state_d == DMA_RD_WAIT) addr_d = src_nxt_c;
        else if (state_d == DMA_WR)                       addr_d = dst_nxt_c;

        // m_wdata doubles as the data register; a copy WR is always entered from RD_WAIT
        wdata_d = '0;
        if (state_d == DMA_WR) begin
            if (fill_q)       wdata_d = fill_val_q;
            else if (capture) wdata_d = m_rdata;
            else              wdata_d = m_wdata;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DMA_IDLE;
        else        state_q <= state_d;
    end

    // Registered status and bus outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            bus_req <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            we_q    <= 1'b0;
        end else begin
            busy    <= busy_d;
            done    <= done_d;
            bus_req <= req_d;
            m_addr  <= addr_d;
            m_wdata <= wdata_d;
            we_q    <= we_d;
        end
    end

    // A write never reaches the bus in a cycle where the grant has been withdrawn
    assign m_we = we_q & bus_gnt;

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: bus memory model, write/done scoreboard.
// Fill-mode tests are included when BUS_DMA_FILL_EN is defined.
module tb_bus_dma_master;
    import mcu_bus_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, bus_req;
    logic          bus_gnt = 1'b0;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [DW-1:0] m_rdata;
`ifdef BUS_DMA_FILL_EN
    logic          fill_mode = 1'b0;
    logic [DW-1:0] fill_value = '0;
`endif

    always #5 clk = ~clk;

    bus_dma_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .bus_req    (bus_req),
        .bus_gnt    (bus_gnt),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_we       (m_we),
        .m_rdata    (m_rdata)
`ifdef BUS_DMA_FILL_EN
        ,
        .fill_mode  (fill_mode),
        .fill_value (fill_value)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    int          exp_done[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] bus_mem   [0:1023];
    logic [31:0] model_mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    // Bus responder: combinational read, write at the clock edge
    assign m_rdata = bus_mem[m_addr[9:0]];

    always @(posedge clk) begin
        if (pl_en)     bus_mem[pl_addr] <= pl_data;
        else if (m_we) bus_mem[m_addr[9:0]] <= m_wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor: every bus write and every done pulse must be predicted
    always @(negedge clk) begin : monitor
        wr_t e;
        int  ed;
        if (rst_n) begin
            if (m_we) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none required (cycle %0d)",
                             m_addr, m_wdata, cyc);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(m_addr), 64'(e.addr));
                    chk("wr_data", 64'(m_wdata), 64'(e.data));
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    note_fail("unexpected_done");
                end else begin
                    ed = exp_done.pop_front();
                    if (ed >= 0) chk("done_cycle", 64'(cyc), 64'(ed));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a[9:0];
        pl_data = d;
        pl_en   = 1'b1;
        model_mem[a[9:0]] = d;
        tick();
        pl_en = 1'b0;
    endtask

    // Reference copy: word i of the block goes from src+i to dst+i
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] sa, da, d;
        for (int i = 0; i < n; i++) begin
            sa = src + 32'(i);
            da = dst + 32'(i);
            d  = model_mem[sa[9:0]];
            model_mem[da[9:0]] = d;
            exp_wr.push_back('{addr: da, data: d});
        end
    endtask

    // Called at #1 after an edge; returns one cycle later with t0 = start cycle
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n,
                            input bit fm, input logic [31:0] fv, output int t0);
        src_addr = s;
        dst_addr = d;
        len      = LW'(n);
`ifdef BUS_DMA_FILL_EN
        fill_mode  = fm;
        fill_value = fv;
`else
        if (fm || (fv != 32'h0)) $display("note: fill arguments ignored in copy-only build");
`endif
        start = 1'b1;
        t0    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input bit rand_gnt, input int maxc);
        int n;
        n = 0;
        while (exp_done.size() != 0 && n < maxc) begin
            tick();
            if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
            n++;
        end
        if (exp_done.size() != 0) begin
            note_fail("done_timeout");
            exp_done.delete();
        end
        chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
        exp_wr.delete();
        bus_gnt = 1'b1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int t0, w0, bad, so, dofs, n;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_wdata", 64'(m_wdata), 64'd0);
        chk("rst_m_we", 64'(m_we), 64'd0);
        tick();
        rst_n = 1'b1;

        // Fill the SRAM page with random words
        for (int a = 32'h100; a < 32'h200; a++) preload(32'(a), $urandom);
        preload(32'h100, 32'h11);
        preload(32'h101, 32'h22);
        preload(32'h102, 32'h33);
        preload(32'h103, 32'h44);

        // Basic copy of 4 words with grant tied high
        bus_gnt = 1'b1;
        w0 = wr_cnt;
        push_copy(32'h100, 32'h180, 4);
        do_start(32'h100, 32'h180, 4, 1'b0, 32'h0, t0);
        exp_done.push_back(t0 + 15);
        @(negedge clk);
        chk("basic_busy", 64'(busy), 64'd1);
        chk("basic_bus_req", 64'(bus_req), 64'd1);
        run_until_done(1'b0, 100);
        chk("basic_write_count", 64'(wr_cnt - w0), 64'd4);

        // Zero-length start: done two cycles later, bus untouched
        tick();
        do_start(32'h100, 32'h180, 0, 1'b0, 32'h0, t0);
        exp_done.push_back(t0 + 2);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0 || m_we !== 1'b0) bad++;
            tick();
        end
        chk("zero_len_bus_quiet", 64'(bad), 64'd0);
        run_until_done(1'b0, 20);

        // Grant withheld for 5 cycles after start
        bus_gnt = 1'b0;
        push_copy(32'h120, 32'h1a0, 2);
        do_start(32'h120, 32'h1a0, 2, 1'b0, 32'h0, t0);
        exp_done.push_back(-1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || m_addr !== 32'h0 || m_we !== 1'b0) bad++;
            tick();
        end
        chk("gnt_wait_req_held", 64'(bad), 64'd0);
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("gnt_rise_still_req", 64'(m_addr), 64'd0);
        tick();
        @(negedge clk);
        chk("first_rd_addr", 64'(m_addr), 64'h120);
        chk("first_rd_we", 64'(m_we), 64'd0);
        run_until_done(1'b0, 100);

        // Grant dropped during the write of word 2 of 3
        tick();
        w0 = wr_cnt;
        push_copy(32'h130, 32'h1b0, 3);
        do_start(32'h130, 32'h1b0, 3, 1'b0, 32'h0, t0);
        exp_done.push_back(-1);
        for (int i = 0; i < 6; i++) tick();
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("gnt_drop_addr", 64'(m_addr), 64'h1b1);
        chk("gnt_drop_we", 64'(m_we), 64'd0);
        tick();
        bus_gnt = 1'b1;
        run_until_done(1'b0, 100);
        chk("gnt_drop_write_count", 64'(wr_cnt - w0), 64'd3);

        // Start while busy is ignored
        tick();
        w0 = wr_cnt;
        push_copy(32'h140, 32'h1c0, 3);
        do_start(32'h140, 32'h1c0, 3, 1'b0, 32'h0, t0);
        exp_done.push_back(t0 + 12);
        for (int i = 0; i < 4; i++) tick();
        do_start(32'h100, 32'h1e0, 5, 1'b0, 32'h0, n);
        run_until_done(1'b0, 100);
        for (int i = 0; i < 10; i++) tick();
        chk("busy_start_write_count", 64'(wr_cnt - w0), 64'd3);
        chk("busy_start_idle", 64'(busy), 64'd0);

        // Asynchronous reset in RD_WAIT of the first word
        do_start(32'h150, 32'h1d0, 4, 1'b0, 32'h0, t0);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_bus_req", 64'(bus_req), 64'd0);
        chk("arst_m_addr", 64'(m_addr), 64'd0);
        chk("arst_m_wdata", 64'(m_wdata), 64'd0);
        chk("arst_m_we", 64'(m_we), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        w0 = wr_cnt;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus_req !== 1'b0 || m_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        chk("arst_stays_idle", 64'(bad), 64'd0);
        chk("arst_no_writes", 64'(wr_cnt - w0), 64'd0);

        // Randomized copies; odd iterations toggle the grant randomly
        for (int k = 0; k < 8; k++) begin
            so   = $urandom_range(0, 111);
            dofs = $urandom_range(0, 111);
            n    = $urandom_range(1, 16);
            push_copy(32'h100 + 32'(so), 32'h180 + 32'(dofs), n);
            do_start(32'h100 + 32'(so), 32'h180 + 32'(dofs), n, 1'b0, 32'h0, t0);
            exp_done.push_back((k % 2 == 0) ? (t0 + 3 + 3 * n) : -1);
            run_until_done(k % 2 == 1, 2000);
            tick();
        end

`ifdef BUS_DMA_FILL_EN
        // Fill mode: one write per cycle with the fill value
        for (int i = 0; i < 8; i++) begin
            model_mem[10'h100 + 10'(i)] = 32'hA5A5A5A5;
            exp_wr.push_back('{addr: 32'h100 + 32'(i), data: 32'hA5A5A5A5});
        end
        do_start(32'h000, 32'h100, 8, 1'b1, 32'hA5A5A5A5, t0);
        exp_done.push_back(t0 + 11);
        tick();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_we !== 1'b1) bad++;
            tick();
        end
        chk("fill_consecutive_writes", 64'(bad), 64'd0);
        run_until_done(1'b0, 50);
`endif

        // Final SRAM page contents against the reference memory
        tick();
        bad = 0;
        for (int a = 32'h100; a < 32'h200; a++)
            if (bus_mem[a] !== model_mem[a]) bad++;
        chk("sram_contents", 64'(bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
